tg_write_arbiter: RTL and testbench

Owns the single write port of the text-grid character buffer. It shares that port between two requesters: the terminal controller (requester 0) and the compiler/status output writer (requester 1). It also contains a built-in clear-screen sequencer that sweeps every cell with a fill character. It sits between the requesters and the text-grid BRAM in the pixel_clk_in domain.

---
 rtl/tg_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_tg_write_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tg_write_arbiter.sv
// tg_write_arbiter
// Owns the single write port of the text-grid character buffer. Two
// requesters share the port with round-robin arbitration on ties, and a
// built-in sequencer sweeps every cell with CLEAR_CHAR on request.
//
// Ports:
//   pixel_clk_in            system clock
//   rst_in                  synchronous active-high reset
//   req0_valid/addr/data    requester 0 (terminal controller) write request
//   req0_ready              requester 0 accepted this cycle (combinational)
//   req1_valid/addr/data    requester 1 (status writer) write request
//   req1_ready              requester 1 accepted this cycle (combinational)
//   clear_req               one-cycle pulse starting a full-screen clear
//   tg_we/tg_addr/tg_input  registered buffer write port
//   clear_busy              high while the sweep is running
//   clear_done              one-cycle pulse aligned with the final clear write
module tg_write_arbiter #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int CLEAR_CHAR    = 32
) (
  input  logic                                       pixel_clk_in,
  input  logic                                       rst_in,
  input  logic                                       req0_valid,
  input  logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] req0_addr,
  input  logic [7:0]                                 req0_data,
  output logic                                       req0_ready,
  input  logic                                       req1_valid,
  input  logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] req1_addr,
  input  logic [7:0]                                 req1_data,
  output logic                                       req1_ready,
  input  logic                                       clear_req,
  output logic                                       tg_we,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr,
  output logic [7:0]                                 tg_input,
  output logic                                       clear_busy,
  output logic                                       clear_done
);

  localparam int N  = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int AW = $clog2(N);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          last_grant, last_grant_nx;
  logic          we_nx;
  logic [AW-1:0] addr_nx;
  logic [7:0]    data_nx;
  logic          busy_nx, done_nx;

  // One extra bit so the range check still works when N is a power of two.
  logic in_range0, in_range1;
  assign in_range0 = ({1'b0, req0_addr} < (AW+1)'(N));
  assign in_range1 = ({1'b0, req1_addr} < (AW+1)'(N));

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    last_grant_nx = last_grant;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    we_nx         = 1'b0;
    addr_nx       = tg_addr;
    data_nx       = tg_input;
    busy_nx       = clear_busy;
    done_nx       = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
        end else begin
          // Round-robin state only moves on a genuine tie.
          if (req0_valid && req1_valid) begin
            if (last_grant) req0_ready = 1'b1;
            else            req1_ready = 1'b1;
            last_grant_nx = ~last_grant;
          end else if (req0_valid) begin
            req0_ready = 1'b1;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
          end

          // Out-of-range requests are accepted but never reach the buffer.
          if (req0_ready && in_range0) begin
            we_nx   = 1'b1;
            addr_nx = req0_addr;
            data_nx = req0_data;
          end else if (req1_ready && in_range1) begin
            we_nx   = 1'b1;
            addr_nx = req1_addr;
            data_nx = req1_data;
          end
        end
      end

      CLEAR: begin
        we_nx   = 1'b1;
        addr_nx = cnt;
        data_nx = 8'(CLEAR_CHAR);
        if (cnt == AW'(N-1)) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      tg_we      <= 1'b0;
      tg_addr    <= '0;
      tg_input   <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_grant <= last_grant_nx;
      tg_we      <= we_nx;
      tg_addr    <= addr_nx;
      tg_input   <= data_nx;
      clear_busy <= busy_nx;
      clear_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_tg_write_arbiter.sv
// Testbench for tg_write_arbiter: directed stimulus pushes expected buffer
// writes into a queue; a monitor pops and compares on every tg_we.
module tb_tg_write_arbiter;

  localparam int N  = 3344;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [7:0]    req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          clear_req;
  logic          tg_we;
  logic [AW-1:0] tg_addr;
  logic [7:0]    tg_input;
  logic          clear_busy, clear_done;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          done;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  tg_write_arbiter #(
    .SCREEN_WIDTH (76),
    .SCREEN_HEIGHT(44),
    .CLEAR_CHAR   (32)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .clear_req   (clear_req),
    .tg_we       (tg_we),
    .tg_addr     (tg_addr),
    .tg_input    (tg_input),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int d, input logic done);
    wr_t w;
    w.addr = AW'(a);
    w.data = 8'(d);
    w.done = done;
    exp_q.push_back(w);
  endtask

  // One cycle of stimulus: drive at negedge, check readies, record the
  // write that the accepted request is expected to produce.
  task automatic step(input logic v0, input int a0, input int d0,
                      input logic v1, input int a1, input int d1,
                      input logic clr, input logic er0, input logic er1);
    @(negedge clk);
    req0_valid = v0; req0_addr = AW'(a0); req0_data = 8'(d0);
    req1_valid = v1; req1_addr = AW'(a1); req1_data = 8'(d1);
    clear_req  = clr;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(er0));
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    if (er0 && v0 && a0 < N) push(a0, d0, 1'b0);
    if (er1 && v1 && a1 < N) push(a1, d1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every tg_we must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tg_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", tg_addr, tg_input);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("tg_addr", 32'(tg_addr), 32'(w.addr));
          chk("tg_input", 32'(tg_input), 32'(w.data));
          chk("clear_done", 32'(clear_done), 32'(w.done));
        end
      end else begin
        chk("clear_done_idle", 32'(clear_done), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    clear_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tg_we", 32'(tg_we), 32'd0);
    chk("rst_tg_addr", 32'(tg_addr), 32'd0);
    chk("rst_tg_input", 32'(tg_input), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: single write from requester 0
    step(1'b1, 77, 97, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();

    // 2: tie for four cycles alternates 0,1,0,1
    step(1'b1, 5, 65, 1'b1, 3000, 66, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5, 65, 1'b1, 3000, 66, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5, 65, 1'b1, 3000, 66, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5, 65, 1'b1, 3000, 66, 1'b0, 1'b0, 1'b1);
    idle();

    // 3: clear beats a pending requester 1, which waits out the sweep
    for (int i = 0; i < N; i++) push(i, 32, (i == N-1));
    step(1'b0, 0, 0, 1'b1, 100, 67, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      step(1'b0, 0, 0, 1'b1, 100, 67, 1'b0, 1'b0, 1'b0);
      if (i == 0 || i == N-1) chk("clear_busy_on", 32'(clear_busy), 32'd1);
    end
    step(1'b0, 0, 0, 1'b1, 100, 67, 1'b0, 1'b0, 1'b1);
    chk("clear_busy_off", 32'(clear_busy), 32'd0);
    idle();

    // 4: clear_req during a sweep is ignored
    for (int i = 0; i < N; i++) push(i, 32, (i == N-1));
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++)
      step(1'b0, 0, 0, 1'b0, 0, 0, (i == 100), 1'b0, 1'b0);
    idle();
    idle();
    chk("sweep2_busy_off", 32'(clear_busy), 32'd0);
    chk("sweep2_drained", 32'(exp_q.size()), 32'd0);

    // 5: out-of-range address accepted without a write
    step(1'b1, 3344, 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 10, 88, 1'b0, 1'b0, 1'b1);
    idle();

    // 6: reset in the middle of a sweep aborts it
    for (int i = 0; i < 500; i++) push(i, 32, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) idle();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; clear_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tg_we", 32'(tg_we), 32'd0);
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_done", 32'(clear_done), 32'd0);
    step(1'b1, 200, 70, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    idle();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
